// File: rtl/sn76489_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sn76489_cmd_sequencer_pkg
// Shared definitions for the SN76489 timed command sequencer:
//   - command word layout (bit 8 selects wait, bits [7:0] carry the payload)
//   - sequencer FSM state encoding
//   - helper that sizes the per-tick cycle counter from TICKDIV
// -----------------------------------------------------------------------------
package sn76489_cmd_sequencer_pkg;

    localparam int CMD_W        = 9;
    localparam int CMD_WAIT_BIT = 8;
    localparam int PAYLOAD_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // Width of a down-counter that must hold TICKDIV-1. A TICKDIV of 1 still
    // needs a one-bit counter so the port and register widths stay legal.
    function automatic int tick_cnt_width(input int tickdiv);
        return (tickdiv > 1) ? $clog2(tickdiv) : 1;
    endfunction

endpackage

// File: rtl/sn76489_cmd_fifo.sv
// -----------------------------------------------------------------------------
// sn76489_cmd_fifo
// Synchronous show-ahead FIFO holding 9-bit sequencer commands.
//   I_clk, I_reset : clock, synchronous active-high reset
//   I_push, I_data : write request and command word (ignored while full)
//   I_pop          : read request (ignored while empty)
//   O_head         : entry at the read pointer, valid whenever O_empty=0
//   O_level        : occupancy, 0..DEPTH
//   O_empty/O_full : occupancy flags derived from O_level
// A push while full is dropped even if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module sn76489_cmd_fifo
    import sn76489_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     I_clk,
    input  logic                     I_reset,
    input  logic                     I_push,
    input  logic [CMD_W-1:0]         I_data,
    input  logic                     I_pop,
    output logic [CMD_W-1:0]         O_head,
    output logic [$clog2(DEPTH):0]   O_level,
    output logic                     O_empty,
    output logic                     O_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push_ok;
    logic             pop_ok;

    assign O_full  = (level == LVL_W'(DEPTH));
    assign O_empty = (level == '0);
    assign push_ok = I_push && !O_full;
    assign pop_ok  = I_pop  && !O_empty;

    // NOTE: the storage array has no reset; only pointers and level define
    // which entries are meaningful, so clearing the RAM would buy nothing.
    always_ff @(posedge I_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= I_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign O_head  = mem[rd_ptr];
    assign O_level = level;

endmodule

// File: rtl/sn76489_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sn76489_cmd_sequencer
// Timed command player in front of the SN76489 PSG Wishbone write port.
// The CPU pushes PSG register bytes and wait commands; they are buffered and
// replayed with exact tick spacing.
//   I_clk, I_reset        : clock, synchronous active-high reset
//   I_cmd_valid/I_cmd_data: command push; bit8=0 PSG byte, bit8=1 wait [7:0] ticks
//   O_cmd_ready           : FIFO not full
//   I_pause               : blocks pops and freezes wait counting
//   O_psg_stb/O_psg_we    : Wishbone strobe / write enable (identical)
//   O_psg_dat             : byte presented to the PSG
//   I_psg_ack             : PSG ack, only honoured while a write is active
//   O_busy                : commands pending or sequencer not idle
//   O_level               : FIFO occupancy
// -----------------------------------------------------------------------------
module sn76489_cmd_sequencer
    import sn76489_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TICKDIV    = 2268
) (
    input  logic                          I_clk,
    input  logic                          I_reset,
    input  logic                          I_cmd_valid,
    input  logic [8:0]                    I_cmd_data,
    output logic                          O_cmd_ready,
    input  logic                          I_pause,
    output logic                          O_psg_stb,
    output logic                          O_psg_we,
    output logic [7:0]                    O_psg_dat,
    input  logic                          I_psg_ack,
    output logic                          O_busy,
    output logic [$clog2(FIFO_DEPTH):0]   O_level
);

    localparam int CNT_W = tick_cnt_width(TICKDIV);
    localparam logic [CNT_W-1:0] SUB_RELOAD = CNT_W'(TICKDIV - 1);

    seq_state_t             state_q, state_d;
    logic [PAYLOAD_W-1:0]   ticks_q, ticks_d;
    logic [CNT_W-1:0]       sub_q,   sub_d;
    logic [PAYLOAD_W-1:0]   dat_q,   dat_d;

    logic                   fifo_pop;
    logic [CMD_W-1:0]       fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;

    sn76489_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .I_push  (I_cmd_valid),
        .I_data  (I_cmd_data),
        .I_pop   (fifo_pop),
        .O_head  (fifo_head),
        .O_level (O_level),
        .O_empty (fifo_empty),
        .O_full  (fifo_full)
    );

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q <= IDLE;
            ticks_q <= '0;
            sub_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ticks_q <= ticks_d;
            sub_q   <= sub_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d  = state_q;
        ticks_d  = ticks_q;
        sub_d    = sub_q;
        dat_d    = dat_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !I_pause) begin
                    fifo_pop = 1'b1;
                    if (fifo_head[CMD_WAIT_BIT]) begin
                        state_d = WAIT;
                        ticks_d = fifo_head[PAYLOAD_W-1:0];
                        sub_d   = SUB_RELOAD;
                    end else begin
                        state_d = WRITE;
                        dat_d   = fifo_head[PAYLOAD_W-1:0];
                    end
                end
            end

            // Ack is only looked at here; the PSG's registered ack trails
            // the strobe by a cycle and lands harmlessly in IDLE.
            WRITE: begin
                if (I_psg_ack) begin
                    state_d = IDLE;
                end
            end

            // Each tick spans TICKDIV unpaused cycles (sub counts
            // TICKDIV-1 down to 0), giving N*TICKDIV cycles for wait(N).
            WAIT: begin
                if (ticks_q == '0) begin
                    state_d = IDLE;
                end else if (!I_pause) begin
                    if (sub_q == '0) begin
                        if (ticks_q == PAYLOAD_W'(1)) begin
                            state_d = IDLE;
                        end else begin
                            ticks_d = ticks_q - PAYLOAD_W'(1);
                            sub_d   = SUB_RELOAD;
                        end
                    end else begin
                        sub_d = sub_q - CNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign O_cmd_ready = !fifo_full;
    assign O_psg_stb   = (state_q == WRITE);
    assign O_psg_we    = (state_q == WRITE);
    assign O_psg_dat   = dat_q;
    assign O_busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_sn76489_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sn76489_cmd_sequencer
// Self-checking bench for sn76489_cmd_sequencer (FIFO_DEPTH=16, TICKDIV=4).
// A queue-based model predicts the outputs every cycle; directed scenarios
// add literal timing expectations on strobe edges.
// -----------------------------------------------------------------------------
module tb_sn76489_cmd_sequencer;

    localparam int DEPTH   = 16;
    localparam int TICKDIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [8:0] cmd_data;
    logic       pause;
    logic       psg_ack = 1'b0;
    logic       ack_en;
    logic       cmd_ready;
    logic       stb;
    logic       we;
    logic [7:0] dat;
    logic       busy;
    logic [4:0] level;

    always #5 clk = ~clk;

    sn76489_cmd_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .TICKDIV    (TICKDIV)
    ) dut (
        .I_clk       (clk),
        .I_reset     (rst),
        .I_cmd_valid (cmd_valid),
        .I_cmd_data  (cmd_data),
        .O_cmd_ready (cmd_ready),
        .I_pause     (pause),
        .O_psg_stb   (stb),
        .O_psg_we    (we),
        .O_psg_dat   (dat),
        .I_psg_ack   (psg_ack),
        .O_busy      (busy),
        .O_level     (level)
    );

    // Edge counter: at a negedge, cyc+1 is the edge that closes the cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PSG slave: registers its ack one cycle after the strobe.
    always @(posedge clk) psg_ack <= ack_en && stb;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // mode 0 idle, 1 write in flight, 2 waiting; a wait is tracked as the
    // number of unpaused cycles still to spend (N*TICKDIV, or 0 for wait(0)).
    logic [8:0] m_q[$];
    int         m_mode;
    logic [7:0] m_dat;
    int         m_left;

    always @(posedge clk) begin
        logic       do_push;
        logic [8:0] c;
        if (rst) begin
            m_q.delete();
            m_mode = 0;
            m_dat  = 8'h00;
            m_left = 0;
        end else begin
            do_push = cmd_valid && (m_q.size() < DEPTH);
            case (m_mode)
                0: if (m_q.size() != 0 && !pause) begin
                    c = m_q.pop_front();
                    if (c[8]) begin
                        m_mode = 2;
                        m_left = int'(c[7:0]) * TICKDIV;
                    end else begin
                        m_mode = 1;
                        m_dat  = c[7:0];
                    end
                end
                1: if (psg_ack) m_mode = 0;
                default: begin
                    if (m_left == 0) m_mode = 0;
                    else if (!pause) begin
                        m_left--;
                        if (m_left == 0) m_mode = 0;
                    end
                end
            endcase
            if (do_push) m_q.push_back(cmd_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("stb",   32'(stb),       32'(m_mode == 1));
            check("we",    32'(we),        32'(m_mode == 1));
            check("dat",   32'(dat),       32'(m_dat));
            check("level", 32'(level),     32'(m_q.size()));
            check("ready", 32'(cmd_ready), 32'(m_q.size() != DEPTH));
            check("busy",  32'(busy),      32'(m_q.size() != 0 || m_mode != 0));
        end
    end

    // ---------------- strobe edge monitor ----------------
    logic       prev_stb = 1'b0;
    int         rise_q[$];
    int         fall_q[$];
    logic [7:0] rdat_q[$];

    always @(negedge clk) begin
        if (stb && !prev_stb) begin
            rise_q.push_back(cyc + 1);
            rdat_q.push_back(dat);
        end
        if (!stb && prev_stb) fall_q.push_back(cyc + 1);
        prev_stb = stb;
    end

    function automatic int rise_at(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -1000;
    endfunction
    function automatic int fall_at(input int i);
        return (i < fall_q.size()) ? fall_q[i] : -1000;
    endfunction
    function automatic int rdat_at(input int i);
        return (i < rdat_q.size()) ? int'(rdat_q[i]) : -1;
    endfunction

    task automatic clear_mon();
        rise_q.delete();
        fall_q.delete();
        rdat_q.delete();
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    int push_edge;

    task automatic push(input logic [8:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("push_wait");
        push_edge = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int p;
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 9'h000;
        pause     = 1'b0;
        ack_en    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_stb",   32'(stb),       32'd0);
        check("rst_we",    32'(we),        32'd0);
        check("rst_dat",   32'(dat),       32'h00);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_level", 32'(level),     32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        chk_en = 1'b1;

        // Single write: stb two cycles after push, held for two cycles.
        clear_mon();
        push(9'h09F);
        p = push_edge;
        wait_idle("t1_idle");
        check("t1_count",   32'(rise_q.size()),      32'd1);
        check("t1_latency", 32'(rise_at(0) - p),     32'd2);
        check("t1_dat",     32'(rdat_at(0)),         32'h9F);
        check("t1_width",   32'(fall_at(0) - rise_at(0)), 32'd2);
        check("t1_busy",    32'(busy),               32'd0);

        // Write, write, wait(3), write: gaps of 1 and 1+12+1 idle-stb cycles.
        clear_mon();
        push(9'h080);
        push(9'h00A);
        push(9'h103);
        push(9'h09F);
        wait_idle("t2_idle");
        check("t2_count", 32'(rise_q.size()), 32'd3);
        check("t2_dat0",  32'(rdat_at(0)), 32'h80);
        check("t2_dat1",  32'(rdat_at(1)), 32'h0A);
        check("t2_dat2",  32'(rdat_at(2)), 32'h9F);
        check("t2_gap_b2b",  32'(rise_at(1) - fall_at(0)), 32'd1);
        check("t2_gap_wait", 32'(rise_at(2) - fall_at(1)), 32'd14);
        check("t2_width1",   32'(fall_at(1) - rise_at(1)), 32'd2);

        // Fill to 16 while paused; 17th push stalls until the first pop.
        clear_mon();
        ack_en = 1'b0;
        pause  = 1'b1;
        for (int i = 0; i < 16; i++) push(9'(9'h020 + i));
        check("t3_full_level", 32'(level),     32'd16);
        check("t3_full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_data  = 9'h030;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_ready", 32'(cmd_ready), 32'd0);
        end
        pause = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_stall_len", 32'(n), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_hold_stb",   32'(stb),   32'd1);
        check("t3_hold_dat",   32'(dat),   32'h20);
        check("t3_hold_level", 32'(level), 32'd16);
        ack_en = 1'b1;
        wait_idle("t3_idle");
        check("t3_count", 32'(rise_q.size()), 32'd17);
        for (int i = 0; i < 17; i++) check("t3_order", 32'(rdat_at(i)), 32'(8'h20 + i));

        // wait(0) between writes; the trailing ack must not cut write 2 short.
        clear_mon();
        push(9'h090);
        push(9'h100);
        push(9'h0BF);
        wait_idle("t4_idle");
        check("t4_count",  32'(rise_q.size()), 32'd2);
        check("t4_gap",    32'(rise_at(1) - fall_at(0)), 32'd3);
        check("t4_width1", 32'(fall_at(1) - rise_at(1)), 32'd2);
        check("t4_dat1",   32'(rdat_at(1)), 32'hBF);

        // wait(2) with 5 paused cycles in the middle; pushes accepted meanwhile.
        clear_mon();
        push(9'h091);
        push(9'h102);
        n = 0;
        while (!stb && n < 20) begin @(negedge clk); n++; end
        while (stb && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) timeout("t5_stb");
        repeat (2) @(negedge clk);
        pause = 1'b1;
        push(9'h0B2);
        check("t5_level1", 32'(level), 32'd1);
        push(9'h0D3);
        check("t5_level2", 32'(level), 32'd2);
        repeat (3) @(negedge clk);
        pause = 1'b0;
        wait_idle("t5_idle");
        check("t5_count",    32'(rise_q.size()), 32'd3);
        check("t5_dat1",     32'(rdat_at(1)), 32'hB2);
        check("t5_dat2",     32'(rdat_at(2)), 32'hD3);
        check("t5_gap_wait", 32'(rise_at(1) - fall_at(0)), 32'd15);
        check("t5_gap_b2b",  32'(rise_at(2) - fall_at(1)), 32'd1);

        // Reset during a write, then a fresh write plays normally.
        ack_en = 1'b0;
        push(9'h0E0);
        push(9'h0E1);
        repeat (2) @(negedge clk);
        check("t6_pre_stb", 32'(stb), 32'd1);
        reset_pulse();
        check("t6_stb",   32'(stb),       32'd0);
        check("t6_level", 32'(level),     32'd0);
        check("t6_busy",  32'(busy),      32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd1);
        ack_en = 1'b1;
        clear_mon();
        push(9'h0E5);
        p = push_edge;
        wait_idle("t6_idle");
        check("t6_latency", 32'(rise_at(0) - p), 32'd2);
        check("t6_dat",     32'(rdat_at(0)), 32'hE5);

        // Reset during a long wait, then a fresh write plays normally.
        push(9'h150);
        push(9'h0AA);
        repeat (5) @(negedge clk);
        check("t7_pre_busy", 32'(busy), 32'd1);
        reset_pulse();
        check("t7_busy",  32'(busy),  32'd0);
        check("t7_level", 32'(level), 32'd0);
        clear_mon();
        push(9'h0E7);
        p = push_edge;
        wait_idle("t7_idle");
        check("t7_count",   32'(rise_q.size()), 32'd1);
        check("t7_latency", 32'(rise_at(0) - p), 32'd2);
        check("t7_dat",     32'(rdat_at(0)), 32'hE7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
